// File: rtl/wait_state_data_memory.sv
// rtl/wait_state_data_memory.sv - wait-state data memory with valid/ready request and held response
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault accesses with nonzero byte-offset bits.
module wait_state_data_memory #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int          OFS       = $clog2(BYTES);
    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [31:0] OFS_MASK  = 32'((1 << OFS) - 1);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (WAIT_STATES > 15) begin : g_wait_states_check
        $error("wait_state_data_memory: WAIT_STATES=%0d exceeds the 4-bit counter", WAIT_STATES);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_next;
    logic [3:0] count, count_next;

    logic                  write_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      be_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  cmd_write;
    logic [31:0]           cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [BYTES-1:0]      cmd_be;
    logic [ADDR_WIDTH-1:0] index;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  fault;
    logic                  commit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    count_next = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (count == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so use the live request there.
    always_comb begin
        cmd_write = (state == S_IDLE) ? req_write : write_q;
        cmd_addr  = (state == S_IDLE) ? req_addr  : addr_q;
        cmd_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
        cmd_be    = (state == S_IDLE) ? req_be    : be_q;
        index        = cmd_addr[ADDR_WIDTH+OFS-1:OFS];
        out_of_range = (cmd_addr >> (ADDR_WIDTH + OFS)) != 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned   = (cmd_addr & OFS_MASK) != 32'd0;
`else
        misaligned   = 1'b0;
`endif
        fault  = out_of_range | misaligned;
        commit = reset && (state_next == S_RESP) && (state != S_RESP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state == S_IDLE && req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clock) begin
        if (commit && cmd_write && !fault) begin
            for (int i = 0; i < BYTES; i++) begin
                if (cmd_be[i]) begin
                    mem[index][8*i +: 8] <= cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err   <= fault;
            resp_rdata <= (fault || cmd_write) ? '0 : mem[index];
        end else if (state == S_RESP && resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);

endmodule
